cpu_step_ctrl: RTL and testbench
================================

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 SHALL provide parameter DIV, default 10: free-run prescale ratio in CLK cycles per CPU tick, legal range >= 2.
REQ-002 SHALL provide parameter DEB_CYCLES, default 16: consecutive stable CLK cycles required to accept a step_btn level.
REQ-003 SHALL provide parameter BURST_W, default 8: width of burst_len.
REQ-004 SHALL provide parameter RST_HOLD, default 4: CLK cycles cpu_rst_n stays low after Reset release, legal range >= 1.
REQ-005 SHALL use one clock, CLK; Reset is asynchronous and active-high.
REQ-006 Port list:
- CLK  in  1  system clock.
- Reset  in  1  async active-high reset.
- mode  in  2  00 halt, 01 run, 10 single-step, 11 burst.
- step_btn  in  1  raw, asynchronous push button.
- burst_len  in  BURST_W  ticks per burst.
- cpu_clk_en  out  1  one-CLK-cycle CPU advance pulse ("tick").
- cpu_rst_n  out  1  active-low CPU reset.
- page_sel  out  1  display page select; toggles on every tick.
- cycle_cnt  out  32  ticks since reset.
- busy  out  1  high in RUN or BURST.

Function
REQ-007 step_btn SHALL pass through a 2-flop synchroniser before debounce.
REQ-008 Debounce:
- The debounced level SHALL change only after the synchronised input differs from it for DEB_CYCLES consecutive cycles.
- Any mismatch gap SHALL restart the count.
REQ-009 A press event SHALL be one cycle, on the debounced 0->1 transition only; holding the button SHALL yield exactly one event.
REQ-010 FSM states SHALL be HOLD, IDLE, RUN, STEP, BURST.
REQ-011 HOLD transitions:
- Stay for RST_HOLD cycles after Reset falls, with cpu_rst_n=0 and no ticks.
- Then go to IDLE and set cpu_rst_n=1.
REQ-012 IDLE transitions:
- mode=01 -> RUN.
- mode=10 with press event -> STEP.
- mode=11 with press event -> BURST, loading remain=burst_len.
- Otherwise stay.
REQ-013 The prescaler SHALL be cleared on entry to RUN and BURST and held at 0 outside those states; in those states it SHALL count 0..DIV-1 and tick when count=DIV-1 (first tick DIV cycles after entry, period DIV thereafter).
REQ-014 RUN SHALL return to IDLE in the cycle after mode!=01 is sampled; a tick coinciding with the exit cycle SHALL still be issued.
REQ-015 STEP SHALL issue exactly one tick in its single cycle and then go to IDLE (press event -> tick latency 1 cycle).
REQ-016 BURST remain counter:
- Each tick SHALL decrement remain; the tick that makes remain 0 SHALL be the last, then go to IDLE.
- burst_len=0 SHALL return to IDLE with no ticks.
- mode!=11 in BURST SHALL abort to IDLE next cycle.
REQ-017 Press events outside IDLE SHALL be ignored and not queued.
REQ-018 On each tick, page_sel SHALL invert and cycle_cnt SHALL increment, wrapping 0xFFFFFFFF -> 0.
REQ-019 cpu_clk_en SHALL be registered, glitch-free, and never high for 2 consecutive cycles (guaranteed by DIV >= 2).
REQ-020 busy SHALL be a registered decode of state, high exactly in RUN and BURST.

Reset
REQ-021 Reset=1 SHALL asynchronously force these values:
- state HOLD, cpu_rst_n=0, cpu_clk_en=0.
- page_sel=0, cycle_cnt=0, busy=0.
- prescaler, remain, debounce counter and debounced level all 0; synchroniser flops 0.
REQ-022 Reset asserted mid-RUN or mid-BURST SHALL abort immediately, with no partial tick, and restart from HOLD.

Verification
REQ-023 Reset sequence: Reset released at cycle 0 -> cpu_rst_n=0 through cycle 3 (RST_HOLD=4), 1 from cycle 4; no ticks.
REQ-024 Free run: mode=01 for 100 cycles, DIV=10 -> exactly 10 ticks spaced 10 cycles; page_sel ends 0; cycle_cnt=10.
REQ-025 Bouncy step: mode=10, step_btn chatters 5 pulses of 3 cycles then holds high 40 cycles -> exactly one tick, 2+16+1 cycles after stable-high onset; cycle_cnt=1.
REQ-026 Burst: mode=11, burst_len=3, one clean press -> 3 ticks at DIV spacing, busy high through the last tick then low.
REQ-026a Burst edge cases: a second press during the burst is ignored; burst_len=0 -> no ticks.
REQ-027 Abort: Reset pulsed 2 cycles mid-burst after 1 tick -> all outputs return to reset values asynchronously; HOLD repeats; no further ticks.
REQ-028 Wrap: cycle_cnt forced/preloaded to 0xFFFFFFFE, 2 ticks in RUN -> 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable sequencer: holds the CPU in reset after power-up, then issues
// one-cycle advance ticks in free-run, single-step (debounced button) or burst mode.
module cpu_step_ctrl #(
  parameter int DIV        = 10,
  parameter int DEB_CYCLES = 16,
  parameter int BURST_W    = 8,
  parameter int RST_HOLD   = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [1:0]         mode,
  input  logic               step_btn,
  input  logic [BURST_W-1:0] burst_len,
  output logic               cpu_clk_en,
  output logic               cpu_rst_n,
  output logic               page_sel,
  output logic [31:0]        cycle_cnt,
  output logic               busy,
  output logic [2:0]         state_dbg
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_BURST = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [PW-1:0]      presc;
  logic [PW-1:0]      presc_nx;
  logic               presc_end;
  logic [BURST_W-1:0] remain;
  logic [BURST_W-1:0] remain_nx;
  logic [HW-1:0]      hold_cnt;
  logic [HW-1:0]      hold_cnt_nx;
  logic               tick_nx;

  logic               sync1;
  logic               sync2;
  logic               deb_level;
  logic [DW-1:0]      deb_cnt;
  logic               deb_done;
  logic               press;

  assign state_dbg = state;

  // Button path: 2-flop synchroniser, then a level accepted only after
  // DEB_CYCLES consecutive disagreeing samples. press marks the accepted rise.
  assign deb_done = (sync2 != deb_level) && (deb_cnt == DW'(DEB_CYCLES - 1));

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      sync1 <= step_btn;
      sync2 <= sync1;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_done) begin
        deb_cnt   <= '0;
        deb_level <= sync2;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
      press <= deb_done & sync2;
    end
  end

  assign presc_end = (presc == PW'(DIV - 1));

  // Prescaler defaults to 0 so it is held cleared outside RUN/BURST and
  // restarts from 0 on every entry.
  always_comb begin
    state_nx    = state;
    presc_nx    = '0;
    remain_nx   = remain;
    hold_cnt_nx = hold_cnt;
    tick_nx     = 1'b0;
    unique case (state)
      S_HOLD: begin
        if (hold_cnt == HW'(RST_HOLD - 1)) begin
          state_nx    = S_IDLE;
          hold_cnt_nx = '0;
        end else begin
          hold_cnt_nx = hold_cnt + HW'(1);
        end
      end
      S_IDLE: begin
        if (mode == MODE_RUN) begin
          state_nx = S_RUN;
        end else if (press && (mode == MODE_STEP)) begin
          state_nx = S_STEP;
          tick_nx  = 1'b1;
        end else if (press && (mode == MODE_BURST)) begin
          state_nx  = S_BURST;
          remain_nx = burst_len;
        end
      end
      S_RUN: begin
        // A tick due in the exit cycle is still issued.
        if (presc_end) begin
          tick_nx = 1'b1;
        end else begin
          presc_nx = presc + PW'(1);
        end
        if (mode != MODE_RUN) begin
          state_nx = S_IDLE;
          presc_nx = '0;
        end
      end
      S_STEP: begin
        state_nx = S_IDLE;
      end
      S_BURST: begin
        // remain reaching 0 ends the burst one cycle after the last tick,
        // so busy covers that tick; burst_len=0 leaves with no tick at all.
        if ((mode != MODE_BURST) || (remain == '0)) begin
          state_nx = S_IDLE;
        end else if (presc_end) begin
          tick_nx   = 1'b1;
          remain_nx = remain - BURST_W'(1);
        end else begin
          presc_nx = presc + PW'(1);
        end
      end
      default: begin
        state_nx = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= S_HOLD;
      presc      <= '0;
      remain     <= '0;
      hold_cnt   <= '0;
      cpu_clk_en <= 1'b0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      page_sel   <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      state      <= state_nx;
      presc      <= presc_nx;
      remain     <= remain_nx;
      hold_cnt   <= hold_cnt_nx;
      cpu_clk_en <= tick_nx;
      cpu_rst_n  <= (state_nx != S_HOLD);
      busy       <= (state_nx == S_RUN) || (state_nx == S_BURST);
      if (tick_nx) begin
        page_sel  <= ~page_sel;
        cycle_cnt <= cycle_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: expected tick cycles are queued per scenario and a
// negedge scoreboard pops one per observed tick, checking time, count and page.
module tb_cpu_step_ctrl;

  localparam int DIV = 10;
  localparam int DEB = 16;
  localparam int BW  = 8;
  localparam int RH  = 4;

  localparam logic [2:0] ST_HOLD  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_STEP  = 3'd3;
  localparam logic [2:0] ST_BURST = 3'd4;

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          step_btn = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic          cpu_clk_en;
  logic          cpu_rst_n;
  logic          page_sel;
  logic [31:0]   cycle_cnt;
  logic          busy;
  logic [2:0]    state_dbg;

  int            checks = 0;
  int            failures = 0;
  logic [31:0]   cyc = '0;
  logic [31:0]   exp_q[$];
  logic [31:0]   exp_cnt = '0;
  logic          exp_page = 1'b0;
  logic          prev_en = 1'b0;

  cpu_step_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB), .BURST_W(BW), .RST_HOLD(RH)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .mode      (mode),
    .step_btn  (step_btn),
    .burst_len (burst_len),
    .cpu_clk_en(cpu_clk_en),
    .cpu_rst_n (cpu_rst_n),
    .page_sel  (page_sel),
    .cycle_cnt (cycle_cnt),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock and cycle stamp
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 32'd1;

  // Scoreboard: every observed tick must match the head of exp_q
  always @(negedge CLK) begin
    logic [31:0] t;
    if (!Reset && cpu_clk_en === 1'b1) begin
      exp_cnt  = exp_cnt + 32'd1;
      exp_page = ~exp_page;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tick: tick at cyc=%0d, none expected", cyc);
      end else begin
        t = exp_q.pop_front();
        if (cyc !== t) begin
          failures++;
          $display("FAIL tick_time: tick at cyc=%0d, expected cyc=%0d", cyc, t);
        end
      end
      checks++;
      if (cycle_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL tick_cycle_cnt: got %0h expected %0h", cycle_cnt, exp_cnt);
      end
      checks++;
      if (page_sel !== exp_page) begin
        failures++;
        $display("FAIL tick_page_sel: got %0b expected %0b", page_sel, exp_page);
      end
      checks++;
      if (prev_en === 1'b1) begin
        failures++;
        $display("FAIL tick_back_to_back: cpu_clk_en high two cycles at cyc=%0d", cyc);
      end
    end
    prev_en = cpu_clk_en;
  end

  // Driver tasks
  task automatic apply_reset();
    @(negedge CLK);
    Reset = 1'b1;
    mode = 2'b00;
    step_btn = 1'b0;
    burst_len = '0;
    exp_q.delete();
    exp_cnt = '0;
    exp_page = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    repeat (RH + 2) @(negedge CLK);
  endtask

  task automatic test_reset();
    logic exp_rst;
    #2 Reset = 1'b1;
    #1;
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL rst_cpu_rst_n: got %0b expected 0", cpu_rst_n); end
    checks++; if (cpu_clk_en !== 1'b0) begin failures++; $display("FAIL rst_clk_en: got %0b expected 0", cpu_clk_en); end
    checks++; if (page_sel !== 1'b0) begin failures++; $display("FAIL rst_page_sel: got %0b expected 0", page_sel); end
    checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL rst_cycle_cnt: got %0h expected 0", cycle_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    checks++; if (state_dbg !== ST_HOLD) begin failures++; $display("FAIL rst_state: got %0d expected %0d", state_dbg, ST_HOLD); end
    repeat (3) @(negedge CLK);
    Reset = 1'b0;
    for (int k = 1; k <= RH + 2; k++) begin
      @(negedge CLK);
      exp_rst = (k >= RH);
      checks++;
      if (cpu_rst_n !== exp_rst) begin
        failures++;
        $display("FAIL hold_cpu_rst_n: cycle %0d got %0b expected %0b", k, cpu_rst_n, exp_rst);
      end
      checks++;
      if (state_dbg !== (exp_rst ? ST_IDLE : ST_HOLD)) begin
        failures++;
        $display("FAIL hold_state: cycle %0d got %0d expected %0d", k, state_dbg, exp_rst ? ST_IDLE : ST_HOLD);
      end
    end
  endtask

  task automatic test_free_run();
    logic [31:0] c0;
    apply_reset();
    c0 = cyc;
    mode = 2'b01;
    for (int k = 0; k < 10; k++) exp_q.push_back(c0 + 32'(11 + 10 * k));
    repeat (50) @(negedge CLK);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL run_busy: got %0b expected 1", busy); end
    checks++; if (state_dbg !== ST_RUN) begin failures++; $display("FAIL run_state: got %0d expected %0d", state_dbg, ST_RUN); end
    repeat (50) @(negedge CLK);
    mode = 2'b00;
    repeat (5) @(negedge CLK);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL run_missing_ticks: %0d left expected 0", exp_q.size()); end
    checks++; if (cycle_cnt !== 32'd10) begin failures++; $display("FAIL run_cycle_cnt: got %0d expected 10", cycle_cnt); end
    checks++; if (page_sel !== 1'b0) begin failures++; $display("FAIL run_page_sel: got %0b expected 0", page_sel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL run_exit_busy: got %0b expected 0", busy); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL run_exit_state: got %0d expected %0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_bouncy_step();
    logic [31:0] c0;
    apply_reset();
    mode = 2'b10;
    for (int p = 0; p < 5; p++) begin
      step_btn = 1'b1;
      repeat (3) @(negedge CLK);
      step_btn = 1'b0;
      repeat (3) @(negedge CLK);
    end
    step_btn = 1'b1;
    c0 = cyc;
    exp_q.push_back(c0 + 32'd19);
    repeat (19) @(negedge CLK);
    checks++; if (cpu_clk_en !== 1'b1) begin failures++; $display("FAIL step_tick: got %0b expected 1", cpu_clk_en); end
    checks++; if (state_dbg !== ST_STEP) begin failures++; $display("FAIL step_state: got %0d expected %0d", state_dbg, ST_STEP); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL step_busy: got %0b expected 0", busy); end
    @(negedge CLK);
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL step_exit: got %0d expected %0d", state_dbg, ST_IDLE); end
    repeat (20) @(negedge CLK);
    step_btn = 1'b0;
    repeat (30) @(negedge CLK);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL step_missing_tick: %0d left expected 0", exp_q.size()); end
    checks++; if (cycle_cnt !== 32'd1) begin failures++; $display("FAIL step_cycle_cnt: got %0d expected 1", cycle_cnt); end
    checks++; if (page_sel !== 1'b1) begin failures++; $display("FAIL step_page_sel: got %0b expected 1", page_sel); end
  endtask

  task automatic test_burst();
    logic [31:0] c0;
    apply_reset();
    mode = 2'b11;
    burst_len = 8'd3;
    @(negedge CLK);
    c0 = cyc;
    step_btn = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(c0 + 32'(29 + 10 * k));
    repeat (20) @(negedge CLK);
    checks++; if (state_dbg !== ST_BURST) begin failures++; $display("FAIL burst_state: got %0d expected %0d", state_dbg, ST_BURST); end
    step_btn = 1'b0;
    repeat (29) @(negedge CLK);
    checks++; if (cpu_clk_en !== 1'b1) begin failures++; $display("FAIL burst_last_tick: got %0b expected 1", cpu_clk_en); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL burst_busy_last: got %0b expected 1", busy); end
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_busy_after: got %0b expected 0", busy); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL burst_exit: got %0d expected %0d", state_dbg, ST_IDLE); end
    repeat (30) @(negedge CLK);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL burst_missing_ticks: %0d left expected 0", exp_q.size()); end
    checks++; if (cycle_cnt !== 32'd3) begin failures++; $display("FAIL burst_cycle_cnt: got %0d expected 3", cycle_cnt); end
  endtask

  task automatic test_burst_edges();
    logic [31:0] c0;
    apply_reset();
    mode = 2'b11;
    burst_len = 8'd5;
    @(negedge CLK);
    c0 = cyc;
    step_btn = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back(c0 + 32'(29 + 10 * k));
    repeat (20) @(negedge CLK);
    step_btn = 1'b0;
    repeat (20) @(negedge CLK);
    step_btn = 1'b1;
    repeat (22) @(negedge CLK);
    checks++; if (state_dbg !== ST_BURST) begin failures++; $display("FAIL edge_repress_state: got %0d expected %0d", state_dbg, ST_BURST); end
    step_btn = 1'b0;
    repeat (30) @(negedge CLK);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL edge_missing_ticks: %0d left expected 0", exp_q.size()); end
    checks++; if (cycle_cnt !== 32'd5) begin failures++; $display("FAIL edge_cycle_cnt: got %0d expected 5", cycle_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL edge_busy: got %0b expected 0", busy); end
    burst_len = 8'd0;
    @(negedge CLK);
    c0 = cyc;
    step_btn = 1'b1;
    repeat (19) @(negedge CLK);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy_entry: got %0b expected 1", busy); end
    @(negedge CLK);
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL zero_exit: got %0d expected %0d", state_dbg, ST_IDLE); end
    repeat (5) @(negedge CLK);
    step_btn = 1'b0;
    repeat (25) @(negedge CLK);
    checks++; if (cycle_cnt !== 32'd5) begin failures++; $display("FAIL zero_cycle_cnt: got %0d expected 5", cycle_cnt); end
  endtask

  task automatic test_random_bursts();
    logic [31:0] c0;
    int          len;
    int          total;
    apply_reset();
    mode = 2'b11;
    total = 0;
    for (int it = 0; it < 3; it++) begin
      len = $urandom_range(1, 4);
      burst_len = BW'(len);
      @(negedge CLK);
      c0 = cyc;
      step_btn = 1'b1;
      for (int k = 1; k <= len; k++) exp_q.push_back(c0 + 32'(19 + 10 * k));
      repeat (20) @(negedge CLK);
      step_btn = 1'b0;
      repeat (10 * len + 30) @(negedge CLK);
      total += len;
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_missing_ticks: %0d left expected 0", exp_q.size()); end
    checks++; if (cycle_cnt !== 32'(total)) begin failures++; $display("FAIL rnd_cycle_cnt: got %0d expected %0d", cycle_cnt, total); end
  endtask

  task automatic test_abort();
    logic [31:0] c0;
    logic        exp_rst;
    apply_reset();
    mode = 2'b11;
    burst_len = 8'd3;
    @(negedge CLK);
    c0 = cyc;
    step_btn = 1'b1;
    exp_q.push_back(c0 + 32'd29);
    repeat (20) @(negedge CLK);
    step_btn = 1'b0;
    repeat (13) @(negedge CLK);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_pre_busy: got %0b expected 1", busy); end
    #2 Reset = 1'b1;
    exp_cnt = '0;
    exp_page = 1'b0;
    #1;
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL abort_cpu_rst_n: got %0b expected 0", cpu_rst_n); end
    checks++; if (cpu_clk_en !== 1'b0) begin failures++; $display("FAIL abort_clk_en: got %0b expected 0", cpu_clk_en); end
    checks++; if (page_sel !== 1'b0) begin failures++; $display("FAIL abort_page_sel: got %0b expected 0", page_sel); end
    checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL abort_cycle_cnt: got %0h expected 0", cycle_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    checks++; if (state_dbg !== ST_HOLD) begin failures++; $display("FAIL abort_state: got %0d expected %0d", state_dbg, ST_HOLD); end
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    for (int k = 1; k <= RH + 1; k++) begin
      @(negedge CLK);
      exp_rst = (k >= RH);
      checks++;
      if (cpu_rst_n !== exp_rst) begin
        failures++;
        $display("FAIL abort_hold: cycle %0d got %0b expected %0b", k, cpu_rst_n, exp_rst);
      end
    end
    repeat (60) @(negedge CLK);
    checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL abort_no_ticks: cycle_cnt %0d expected 0", cycle_cnt); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL abort_missing_tick: %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [31:0] c0;
    apply_reset();
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    @(negedge CLK);
    release dut.cycle_cnt;
    @(negedge CLK);
    checks++; if (cycle_cnt !== 32'hFFFF_FFFE) begin failures++; $display("FAIL wrap_preload: got %0h expected fffffffe", cycle_cnt); end
    c0 = cyc;
    mode = 2'b01;
    exp_q.push_back(c0 + 32'd11);
    exp_q.push_back(c0 + 32'd21);
    repeat (21) @(negedge CLK);
    mode = 2'b00;
    repeat (5) @(negedge CLK);
    checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL wrap_cycle_cnt: got %0h expected 0", cycle_cnt); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_missing_ticks: %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_bouncy_step();
    test_burst();
    test_burst_edges();
    test_random_bursts();
    test_abort();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
